// File: rtl/frame_len_acc_pkg.sv
// Shared types and constants for the frame length accumulator.
package frame_len_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // All-ones keep mask for a beat of w bytes (w <= 64).
    function automatic logic [63:0] keep_all_ones(input int unsigned w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/frame_len_acc_thermo_to_len.sv
// Thermometer keep mask to byte count: number of set bits in keep.
module thermo_to_len #(
    parameter int KEEP_W = 8,
    parameter int LEN_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [LEN_W-1:0]  len
);

    always_comb begin
        len = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            len = len + LEN_W'(keep[i]);
        end
    end

endmodule

// File: rtl/frame_len_acc.sv
// Per-frame valid-byte accumulator with a held valid/ready result port.
// Optional keep checking and err output: define FRAME_LEN_ACC_CHECK_EN.
module frame_len_acc
    import frame_len_acc_pkg::*;
#(
    parameter int KEEP_W = 8,
    parameter int LEN_W  = $clog2(KEEP_W + 1),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [KEEP_W-1:0] in_keep_i,
    input  logic              in_last_i,
    output logic              len_valid_o,
    input  logic              len_ready_i,
    output logic [CNT_W-1:0]  len_o,
    output logic              len_ovf_o
`ifdef FRAME_LEN_ACC_CHECK_EN
    ,
    output logic              err_o
`endif
);

    localparam logic [CNT_W-1:0] FULL_BEAT = CNT_W'(KEEP_W);

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic             ovf_acc;
    logic [LEN_W-1:0] beat_len;
    logic [CNT_W-1:0] addend;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sum_sat;
    logic             sum_ovf;

    thermo_to_len #(
        .KEEP_W (KEEP_W),
        .LEN_W  (LEN_W)
    ) u_thermo_to_len (
        .keep (in_keep_i),
        .len  (beat_len)
    );

    // Non-last beats count as full whatever their keep says.
    assign addend  = in_last_i ? CNT_W'(beat_len) : FULL_BEAT;
    assign sum     = {1'b0, acc} + {1'b0, addend};
    assign sum_ovf = sum[CNT_W];
    assign sum_sat = sum_ovf ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    assign in_ready_o = (state == ACC);

`ifdef FRAME_LEN_ACC_CHECK_EN
    localparam logic [KEEP_W-1:0] KEEP_FULL = KEEP_W'(keep_all_ones(KEEP_W));

    logic             err_acc;
    logic             beat_err;
    logic [KEEP_W-1:0] keep_inc;

    assign keep_inc = in_keep_i + KEEP_W'(1);
    assign beat_err = ((in_keep_i & keep_inc) != '0) ||
                      (!in_last_i && (in_keep_i != KEEP_FULL));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACC;
            acc         <= '0;
            ovf_acc     <= 1'b0;
            len_valid_o <= 1'b0;
            len_o       <= '0;
            len_ovf_o   <= 1'b0;
`ifdef FRAME_LEN_ACC_CHECK_EN
            err_acc     <= 1'b0;
            err_o       <= 1'b0;
`endif
        end else begin
            case (state)
                ACC: begin
                    if (in_valid_i) begin
                        if (in_last_i) begin
                            len_o       <= sum_sat;
                            len_ovf_o   <= ovf_acc | sum_ovf;
                            len_valid_o <= 1'b1;
                            acc         <= '0;
                            ovf_acc     <= 1'b0;
                            state       <= HOLD;
`ifdef FRAME_LEN_ACC_CHECK_EN
                            err_o       <= err_acc | beat_err;
                            err_acc     <= 1'b0;
`endif
                        end else begin
                            acc     <= sum_sat;
                            ovf_acc <= ovf_acc | sum_ovf;
`ifdef FRAME_LEN_ACC_CHECK_EN
                            err_acc <= err_acc | beat_err;
`endif
                        end
                    end
                end
                HOLD: begin
                    // len_valid_o is always high in HOLD, so ready alone completes the handshake.
                    if (len_ready_i) begin
                        len_valid_o <= 1'b0;
                        state       <= ACC;
`ifdef FRAME_LEN_ACC_CHECK_EN
                        err_o       <= 1'b0;
`endif
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
